// File: rtl/hit_registrar_pkg.sv
// Shared types and defaults for the hit registrar.
// State encoding is visible on state_out for debug.
package hit_registrar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_COOLDOWN = 3'd2,
    ST_REARM    = 3'd3,
    ST_WON      = 3'd4
  } hit_state_t;

  localparam int DEF_CONFIRM_FRAMES  = 2;
  localparam int DEF_COOLDOWN_FRAMES = 30;
  localparam int DEF_WIN_SCORE       = 5;
  localparam int DEF_SCORE_WIDTH     = 4;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/hit_registrar_frame_counter.sv
// Loadable frame down-counter with zero/one flags.
// Shared between the confirm streak and the cooldown window.
module hit_registrar_frame_counter
  import hit_registrar_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load_in,
  input  logic [W-1:0] load_val_in,
  input  logic         dec_in,
  output logic         zero_out,
  output logic         one_out
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = load_val_in;
    end else if (dec_in && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_out = (cnt_q == '0);
  assign one_out  = (cnt_q == W'(1));

endmodule

// File: rtl/hit_registrar.sv
// Debounced hit registration FSM with cooldown, re-arm,
// saturating round score and sticky win flag.
module hit_registrar
  import hit_registrar_pkg::*;
#(
  parameter int CONFIRM_FRAMES  = DEF_CONFIRM_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int WIN_SCORE       = DEF_WIN_SCORE,
  parameter int SCORE_WIDTH     = DEF_SCORE_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   frame_tick_in,
  input  logic                   is_intersecting_in,
  input  logic                   swing_valid_in,
  input  logic                   round_reset_in,
  output logic                   hit_out,
  output logic [SCORE_WIDTH-1:0] score_out,
  output logic                   cooldown_out,
  output logic                   won_out,
  output logic [2:0]             state_out
);

  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = {SCORE_WIDTH{1'b1}};
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL   = SCORE_WIDTH'(WIN_SCORE);

  hit_state_t             state_q, state_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   hit_q, hit_d;

  logic                   frame_hit;
  logic                   reg_hit;
  logic [SCORE_WIDTH-1:0] score_inc;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic                   cnt_one;

  assign frame_hit = frame_tick_in & swing_valid_in & is_intersecting_in;
  assign score_inc = (score_q == SCORE_MAX) ? score_q
                                            : score_q + SCORE_WIDTH'(1);

  // In CONFIRM the counter holds the frames still needed.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    hit_d    = 1'b0;
    reg_hit  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (round_reset_in) begin
      state_d  = ST_IDLE;
      score_d  = '0;
      cnt_load = 1'b1;
    end else if (frame_tick_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_hit) begin
            if (CONFIRM_FRAMES == 1) begin
              reg_hit = 1'b1;
            end else begin
              state_d  = ST_CONFIRM;
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(CONFIRM_FRAMES - 1);
            end
          end
        end
        ST_CONFIRM: begin
          if (!frame_hit) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
          end else if (cnt_one || cnt_zero) begin
            reg_hit = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_COOLDOWN: begin
          cnt_dec = 1'b1;
          if (cnt_one || cnt_zero) begin
            state_d = ST_REARM;
          end
        end
        ST_REARM: begin
          if (!frame_hit) begin
            state_d = ST_IDLE;
          end
        end
        ST_WON: begin
          state_d = ST_WON;
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end
      endcase
      if (reg_hit) begin
        hit_d    = 1'b1;
        score_d  = score_inc;
        cnt_load = 1'b1;
        if (score_inc == WIN_VAL) begin
          state_d = ST_WON;
        end else if (COOLDOWN_FRAMES == 0) begin
          state_d = ST_REARM;
        end else begin
          state_d = ST_COOLDOWN;
          cnt_val = CNT_W'(COOLDOWN_FRAMES);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  end

  hit_registrar_frame_counter #(
    .W (CNT_W)
  ) u_frame_counter (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (cnt_load),
    .load_val_in (cnt_val),
    .dec_in      (cnt_dec),
    .zero_out    (cnt_zero),
    .one_out     (cnt_one)
  );

  assign hit_out      = hit_q;
  assign score_out    = score_q;
  assign cooldown_out = (state_q == ST_COOLDOWN);
  assign won_out      = (state_q == ST_WON);
  assign state_out    = state_q;

endmodule

// File: tb/tb_hit_registrar.sv
// Directed bench: default-parameter instance plus a
// CONFIRM=1 / COOLDOWN=0 corner instance on shared stimulus.
module tb_hit_registrar;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       flag = 1'b0;
  logic       valid = 1'b0;
  logic       rr = 1'b0;

  logic       hit_a, cool_a, won_a;
  logic [3:0] score_a;
  logic [2:0] state_a;
  logic       hit_b, cool_b, won_b;
  logic [3:0] score_b;
  logic [2:0] state_b;

  int tests = 0;
  int fails = 0;
  int hits_seen;

  always #5 clk = ~clk;

  hit_registrar #(
    .CONFIRM_FRAMES  (2),
    .COOLDOWN_FRAMES (30),
    .WIN_SCORE       (5),
    .SCORE_WIDTH     (4)
  ) dut_a (
    .clk_in             (clk),
    .rst_in             (rst),
    .frame_tick_in      (tick),
    .is_intersecting_in (flag),
    .swing_valid_in     (valid),
    .round_reset_in     (rr),
    .hit_out            (hit_a),
    .score_out          (score_a),
    .cooldown_out       (cool_a),
    .won_out            (won_a),
    .state_out          (state_a)
  );

  hit_registrar #(
    .CONFIRM_FRAMES  (1),
    .COOLDOWN_FRAMES (0),
    .WIN_SCORE       (5),
    .SCORE_WIDTH     (4)
  ) dut_b (
    .clk_in             (clk),
    .rst_in             (rst),
    .frame_tick_in      (tick),
    .is_intersecting_in (flag),
    .swing_valid_in     (valid),
    .round_reset_in     (rr),
    .hit_out            (hit_b),
    .score_out          (score_b),
    .cooldown_out       (cool_b),
    .won_out            (won_b),
    .state_out          (state_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs at a negedge, advance through one posedge.
  task automatic cyc(input logic t, input logic f, input logic v);
    tick  = t;
    flag  = f;
    valid = v;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_state", state_a, 0);
    check("rst_score", score_a, 0);
    check("rst_hit", hit_a, 0);
    check("rst_cool", cool_a, 0);
    check("rst_won", won_a, 0);
    rst = 1'b0;

    // async reset mid-CONFIRM
    cyc(1, 1, 1);
    check("confirm_entry", state_a, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_state", state_a, 0);
    check("async_rst_score", score_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // no tick: no change
    cyc(0, 1, 1);
    check("no_tick_idle", state_a, 0);

    // debounce
    cyc(1, 1, 1);
    check("deb1_state", state_a, 1);
    check("deb1_hit", hit_a, 0);
    cyc(1, 1, 1);
    check("deb2_hit", hit_a, 1);
    check("deb2_score", score_a, 1);
    check("deb2_state", state_a, 2);
    check("deb2_cool", cool_a, 1);
    cyc(0, 1, 1);
    check("hit_one_cycle", hit_a, 0);

    // flag held 40 back-to-back ticks
    hits_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 1, 1);
      if (hit_a) hits_seen++;
      check($sformatf("cool_state_%0d", i), state_a, (i < 30) ? 2 : 3);
    end
    check("rest_no_hit", hits_seen, 0);
    check("rest_score", score_a, 1);
    cyc(1, 0, 1);
    check("rearm_drop", state_a, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    check("second_hit", hit_a, 1);
    check("second_score", score_a, 2);

    // round reset
    rr = 1'b1;
    cyc(1, 1, 1);
    rr = 1'b0;
    check("rr_score", score_a, 0);
    check("rr_state", state_a, 0);

    // broken streak
    hits_seen = 0;
    cyc(1, 1, 1);
    check("bs1", state_a, 1);
    cyc(1, 0, 1);
    if (hit_a) hits_seen++;
    check("bs2", state_a, 0);
    cyc(1, 1, 1);
    check("bs3", state_a, 1);
    cyc(1, 0, 1);
    if (hit_a) hits_seen++;
    check("bs4", state_a, 0);
    check("bs_hits", hits_seen, 0);
    check("bs_score", score_a, 0);

    // five strikes to win
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 1);
      cyc(1, 1, 1);
      check($sformatf("win_hit_%0d", k), hit_a, 1);
      check($sformatf("win_score_%0d", k), score_a, k);
      if (k < 5) begin
        for (int j = 0; j < 30; j++) cyc(1, 0, 1);
        check($sformatf("win_rearm_%0d", k), state_a, 3);
        cyc(1, 0, 1);
        check($sformatf("win_idle_%0d", k), state_a, 0);
      end
    end
    check("won_flag", won_a, 1);
    check("won_state", state_a, 4);
    hits_seen = 0;
    for (int j = 0; j < 4; j++) begin
      cyc(1, 1, 1);
      if (hit_a) hits_seen++;
    end
    check("won_frozen_score", score_a, 5);
    check("won_frozen_hits", hits_seen, 0);
    check("won_sticky", won_a, 1);
    rr = 1'b1;
    cyc(0, 0, 0);
    rr = 1'b0;
    check("won_rr_score", score_a, 0);
    check("won_rr_state", state_a, 0);
    check("won_rr_flag", won_a, 0);

    // round reset beats confirming tick
    cyc(1, 1, 1);
    check("sim_confirm", state_a, 1);
    rr = 1'b1;
    cyc(1, 1, 1);
    rr = 1'b0;
    check("sim_hit", hit_a, 0);
    check("sim_score", score_a, 0);
    check("sim_state", state_a, 0);

    // invalid swing is a miss
    cyc(1, 1, 0);
    check("inv_idle", state_a, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    check("inv_confirm_miss", state_a, 0);
    check("inv_hit", hit_a, 0);

    // corner instance: CONFIRM=1, COOLDOWN=0
    rr = 1'b1;
    cyc(0, 0, 0);
    rr = 1'b0;
    check("b_clear", state_b, 0);
    cyc(1, 1, 1);
    check("b_hit1", hit_b, 1);
    check("b_score1", score_b, 1);
    check("b_rearm", state_b, 3);
    check("b_no_cool", cool_b, 0);
    cyc(1, 1, 1);
    check("b_rest_hit", hit_b, 0);
    check("b_rest_state", state_b, 3);
    cyc(1, 0, 1);
    check("b_idle", state_b, 0);
    cyc(1, 1, 1);
    check("b_hit2", hit_b, 1);
    cyc(1, 0, 1);
    check("b_idle2", state_b, 0);
    cyc(1, 1, 1);
    check("b_score3", score_b, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hit_registrar.md
Name: hit_registrar

Overview:
- Frame-rate consumer of the saber/opponent intersection flag produced by the intersection detector stage.
- Debounces the flag over consecutive frames, registers a single hit per strike, and enforces a cooldown plus re-arm before the next hit.
- Keeps a saturating per-round score and a sticky win flag for the game-state / display logic downstream.

Parameters:
- CONFIRM_FRAMES, 2: consecutive sampled frames with intersection required to register a hit (legal range 1..15).
- COOLDOWN_FRAMES, 30: frames ignored after a hit (legal range 0..255).
- WIN_SCORE, 5: score value that ends the round (legal range 1..2^SCORE_WIDTH-1).
- SCORE_WIDTH, 4: width of the score counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- frame_tick_in  input  1  one-cycle pulse per video frame; the only cycle on which inputs are sampled
- is_intersecting_in  input  1  combinational intersection flag from the detector
- swing_valid_in  input  1  saber endpoints are tracked and valid this frame
- round_reset_in  input  1  synchronous round clear
- hit_out  output  1  one-cycle pulse when a hit is registered
- score_out  output  SCORE_WIDTH  current round score
- cooldown_out  output  1  high while in COOLDOWN
- won_out  output  1  high while in WON
- state_out  output  3  encoded FSM state, for debug

Behaviour:
- Reset, asynchronous on rst_in high:
  - state = IDLE.
  - All counters = 0, score_out = 0.
  - hit_out, cooldown_out and won_out = 0.
- round_reset_in: same clear as reset but synchronous. It wins over frame_tick_in in the same cycle.
- A "frame hit" is frame_tick_in & swing_valid_in & is_intersecting_in.
- With frame_tick_in low, no state or counter changes. hit_out is low except for its pulse.
- hit_out is registered: high for exactly the one cycle following the clock edge that completes confirmation. score_out updates on that same edge.
- States are IDLE, CONFIRM, COOLDOWN, REARM, WON.
- IDLE, on tick:
  - Frame hit with CONFIRM_FRAMES = 1: register the hit.
  - Frame hit with CONFIRM_FRAMES > 1: go to CONFIRM, confirm_cnt = 1.
  - Otherwise stay in IDLE.
- CONFIRM, on tick:
  - Frame hit with confirm_cnt+1 = CONFIRM_FRAMES: register the hit.
  - Frame hit otherwise: confirm_cnt increments.
  - Non-hit frame: go to IDLE, confirm_cnt = 0. Non-consecutive frames never accumulate.
- Registering a hit:
  - hit_out pulses and score increments.
  - If the new score equals WIN_SCORE, go to WON.
  - Else, if COOLDOWN_FRAMES = 0, go to REARM.
  - Else go to COOLDOWN with cool_cnt = COOLDOWN_FRAMES.
- COOLDOWN, on tick: cool_cnt decrements. When the pre-decrement value is 1, go to REARM. The flag is ignored throughout.
- REARM, on tick: a non-hit frame (flag low or swing invalid) goes to IDLE. Otherwise stay. A saber left resting inside the box never scores twice.
- WON:
  - Sticky; won_out = 1. The score is frozen and ignores ticks.
  - Exit only via round_reset_in or rst_in.
- Score saturates at 2^SCORE_WIDTH-1. This is unreachable when WIN_SCORE is legal, but must be enforced anyway.
- state_out encoding: IDLE = 0, CONFIRM = 1, COOLDOWN = 2, REARM = 3, WON = 4.
- cooldown_out and won_out are decoded from the state register; no extra latency.
- Back-to-back ticks on consecutive cycles are legal and each one is processed.
- The flag is a combinational input sampled on the tick edge. The upstream stage must hold stable coordinates for at least one cycle around the tick.

Decomposition:
- Shared package (types.svh): hit_state_t enum with the encoding above, and default constants for CONFIRM_FRAMES, COOLDOWN_FRAMES and WIN_SCORE.
- One natural sub-module: frame_counter, a loadable down-counter with enable = frame_tick_in and a zero/one flag. It serves both cool_cnt and confirm_cnt.
- The FSM and score logic stay in hit_registrar.

Test Plan:
- Reset / debounce (CONFIRM=2): rst_in asserted mid-CONFIRM → immediate IDLE, score 0. Then two consecutive frame hits → hit_out one cycle after the 2nd tick, score 1, state COOLDOWN.
- Broken streak: frame hit, non-hit, frame hit, non-hit → no hit_out, score 0, state back to IDLE after each miss.
- Cooldown and re-arm: hit registered, flag held high for 40 ticks (COOLDOWN=30) → COOLDOWN for exactly 30 ticks, then REARM, no 2nd hit. Drop the flag for one tick → IDLE; two more frame hits → score 2.
- Win: five full strikes with WIN_SCORE=5 → 5th hit_out pulses, score 5, won_out high. Further frame hits are ignored; round_reset_in → score 0, IDLE.
- Simultaneous events: round_reset_in on the same cycle as the confirming tick → no hit_out, score 0. Frame hit with swing_valid_in=0 → treated as a miss.
- Parameter corners: CONFIRM=1 and COOLDOWN=0 → hit on the first frame hit and direct entry to REARM. Ticks on consecutive clocks are each counted.
